prog_ram: RTL and testbench

Parametrised, loadable program memory for the 4-bit microprocessor: a synchronous single-clock RAM with a registered instruction-fetch read port and a streaming loader port. A new program can be written at run time without resynthesis. The block sits between the program counter (read side) and a host or switch/UART loader (write side). While loading or initialising, it asserts `busy` so the core can be held.

---
 rtl/prog_ram.sv | 147 ++++++++++++++
 tb/tb_prog_ram.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram.sv
// prog_ram: loadable program memory with a registered fetch port and a streaming loader.
// Define PROG_RAM_BOOT_EN to write a built-in boot image after every reset.
module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'hB0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {INIT, IDLE, LOAD, FILL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              rd_fire;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

`ifdef PROG_RAM_BOOT_EN
  function automatic logic [DATA_W-1:0] boot_word(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] w;
    case (int'(a))
      0:       w = DATA_W'(8'h08);
      1:       w = DATA_W'(8'h19);
      2:       w = DATA_W'(8'h20);
      3:       w = DATA_W'(8'h10);
      4:       w = DATA_W'(8'h70);
      5:       w = DATA_W'(8'h00);
      6:       w = DATA_W'(8'h14);
      7:       w = DATA_W'(8'h04);
      8:       w = DATA_W'(8'hB2);
      default: w = FILL_WORD;
    endcase
    return w;
  endfunction
`endif

  assign accept  = (state == LOAD) && ld_valid && ld_ready;
  assign rd_fire = rd_en && !busy;

  // All writes go through ptr; the state picks the source.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = ld_data;
    case (state)
      LOAD: wr_en = accept;
      FILL: begin
        wr_en   = 1'b1;
        wr_data = FILL_WORD;
      end
`ifdef PROG_RAM_BOOT_EN
      INIT: begin
        wr_en   = 1'b1;
        wr_data = boot_word(ptr);
      end
`endif
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef PROG_RAM_BOOT_EN
      state <= INIT;
      busy  <= 1'b1;
`else
      state <= IDLE;
      busy  <= 1'b0;
`endif
      ptr      <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      ld_done  <= 1'b0;
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_addr];
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ptr      <= '0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
              state    <= IDLE;
              ld_ready <= 1'b0;
              busy     <= 1'b0;
              ld_done  <= 1'b1;
            end else if (ld_last) begin
              state    <= FILL;
              ld_ready <= 1'b0;
            end
          end
        end
        FILL: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ld_done <= 1'b1;
          end
        end
`ifdef PROG_RAM_BOOT_EN
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: directed table-driven bench for prog_ram.
// Readback tables plus hand sequences for load, fill, blocking and reset corners.
module tb_prog_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  prog_ram dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] a, input logic [7:0] e);
    vec_t v;
    v.addr = a;
    v.exp  = e;
    vq.push_back(v);
  endtask

  // Back-to-back reads: each word must appear one cycle after its request.
  task automatic run_vq(input string nm);
    foreach (vq[i]) begin
      rd_en   = 1'b1;
      rd_addr = vq[i].addr;
      step();
      chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
      chk($sformatf("%s_data@%0d", nm, vq[i].addr), 32'(rd_data),
          32'(vq[i].exp));
    end
    rd_en = 1'b0;
    step();
    chk({nm, "_idle"}, 32'(rd_valid), 32'd0);
    vq.delete();
  endtask

  task automatic wait_idle(input string nm, input int exp_n);
    int n = 0;
    while (busy && n < 64) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    step();
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
`ifdef PROG_RAM_BOOT_EN
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    wait_idle("boot_cycles", 16);
    add(0, 8'h08); add(1, 8'h19); add(2, 8'h20); add(3, 8'h10);
    add(4, 8'h70); add(5, 8'h00); add(6, 8'h14); add(7, 8'h04);
    add(8, 8'hB2);
    for (int a = 9; a < 16; a++) add(4'(a), 8'hB0);
    run_vq("boot");
`else
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
`endif

    // Short load with ld_last on the third word
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("short_ready", 32'(ld_ready), 32'd1);
    chk("short_busy", 32'(busy), 32'd1);
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    step();
    ld_data  = 8'h55;
    step();
    ld_data  = 8'h3C;
    ld_last  = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("fill_ready", 32'(ld_ready), 32'd0);
    n = 0;
    while (!ld_done && n < 40) begin
      step();
      n++;
    end
    chk("fill_cycles", 32'(n), 32'd13);
    chk("fill_busy", 32'(busy), 32'd0);
    step();
    chk("done_pulse", 32'(ld_done), 32'd0);

    add(0, 8'hAA); add(1, 8'h55); add(2, 8'h3C); add(3, 8'hB0);
    add(7, 8'hB0); add(14, 8'hB0); add(15, 8'hB0);
    run_vq("short");

    // ld_start with a read in IDLE: read served, loader opens
    rd_en    = 1'b1;
    rd_addr  = 4'd2;
    ld_start = 1'b1;
    step();
    rd_en    = 1'b0;
    ld_start = 1'b0;
    chk("sim_valid", 32'(rd_valid), 32'd1);
    chk("sim_data", 32'(rd_data), 32'h3C);
    chk("sim_ready", 32'(ld_ready), 32'd1);

    // Read during LOAD is dropped
    rd_en   = 1'b1;
    rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    chk("blk_valid", 32'(rd_valid), 32'd0);
    chk("blk_data", 32'(rd_data), 32'h3C);

    // Full load without ld_last, then a stray 17th word
    ld_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_ready%0d", i), 32'(ld_ready), 32'd1);
      ld_data = 8'(i);
      step();
    end
    ld_data = 8'hFF;
    chk("full_done", 32'(ld_done), 32'd1);
    chk("full_ready_end", 32'(ld_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    step();
    ld_valid = 1'b0;
    chk("stray_done", 32'(ld_done), 32'd0);
    chk("stray_ready", 32'(ld_ready), 32'd0);

    for (int a = 0; a < 16; a++) add(4'(a), 8'(a));
    run_vq("full");

    // Reset in the middle of a load
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'h11;
    step();
    ld_data  = 8'h22;
    step();
    ld_data  = 8'h33;
    step();
    ld_data  = 8'h44;
    rst_n    = 1'b0;
    #1;
    chk("mid_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_ld_ready", 32'(ld_ready), 32'd0);
    chk("mid_ld_done", 32'(ld_done), 32'd0);
    step();
    ld_valid = 1'b0;
    rst_n    = 1'b1;
`ifdef PROG_RAM_BOOT_EN
    wait_idle("reboot_cycles", 16);
    add(0, 8'h08); add(2, 8'h20); add(8, 8'hB2); add(9, 8'hB0);
    run_vq("reboot");
`else
    chk("mid_busy", 32'(busy), 32'd0);
    step();
    add(0, 8'h11); add(1, 8'h22); add(2, 8'h33); add(3, 8'h03);
    add(4, 8'h04);
    run_vq("keep");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
